// File: rtl/read_operand.sv
// Register file, source-operand fetch and pending-write scoreboard.
// Build with READ_OPERAND_BYPASS_EN to forward same-cycle write-back data.
module read_operand #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        wb_add,
  input  logic              wb_order,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] ar_data,
  output logic [DATA_W-1:0] br_data,
  output logic [2:0]        rs_add,
  output logic [2:0]        rd_add,
  output logic              op_valid,
  input  logic              op_ready
);

`ifdef READ_OPERAND_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic [DATA_W-1:0] regs [REG_N];
  logic [REG_N-1:0]  pending;
  logic [REG_N-1:0]  pend_nxt;

  logic [1:0] op1;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [3:0] op3;
  logic       unused_low;

  assign op1        = instr[15:14];
  assign ra         = instr[13:11];
  assign rb         = instr[10:8];
  assign op3        = instr[7:4];
  assign unused_low = ^instr[3:0];

  logic use_a, use_b;
  logic byp_a, byp_b;
  logic blk_a, blk_b;
  logic accept;
  logic has_dst;
  logic [2:0] dst;
  logic [DATA_W-1:0] a_val, b_val;

  assign use_a = (op1 == 2'b11) || (op1 == 2'b01);
  assign use_b = (op1 != 2'b10);

  assign byp_a = BYP && wb_order && (wb_add == ra);
  assign byp_b = BYP && wb_order && (wb_add == rb);

  assign blk_a = use_a && pending[ra] && !byp_a;
  assign blk_b = use_b && pending[rb] && !byp_b;

  assign instr_ready = !reset && !blk_a && !blk_b
                    && (!op_valid || op_ready);
  assign accept = instr_valid && instr_ready;

  // Unused operands capture zero.
  always_comb begin
    a_val = '0;
    b_val = '0;
    if (use_a) a_val = byp_a ? wb_data : regs[ra];
    if (use_b) b_val = byp_b ? wb_data : regs[rb];
  end

  always_comb begin
    has_dst = 1'b0;
    dst     = rb;
    case (op1)
      2'b11: has_dst = !(op3 inside {4'd7, 4'd13, 4'd14, 4'd15});
      2'b10: has_dst = (ra == 3'd0);
      2'b00: begin
        has_dst = 1'b1;
        dst     = ra;
      end
      default: has_dst = 1'b0;
    endcase
  end

  // A set from a new accept overrides a same-cycle write-back clear.
  always_comb begin
    pend_nxt = pending;
    if (wb_order) pend_nxt[wb_add] = 1'b0;
    if (accept && has_dst) pend_nxt[dst] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      pending  <= '0;
      op_valid <= 1'b0;
      ar_data  <= '0;
      br_data  <= '0;
      rs_add   <= '0;
      rd_add   <= '0;
    end else begin
      if (wb_order) regs[wb_add] <= wb_data;
      pending <= pend_nxt;
      if (accept) begin
        op_valid <= 1'b1;
        ar_data  <= a_val;
        br_data  <= b_val;
        rs_add   <= ra;
        rd_add   <= rb;
      end else if (op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_read_operand.sv
// Bench for read_operand: directed scenarios plus random traffic
// checked against a register/scoreboard model of the operand stage.
module tb_read_operand;

`ifdef READ_OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  wb_add;
  logic        wb_order;
  logic [15:0] wb_data;
  logic [15:0] ar_data;
  logic [15:0] br_data;
  logic [2:0]  rs_add;
  logic [2:0]  rd_add;
  logic        op_valid;
  logic        op_ready;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  read_operand dut (
    .clock(clock), .reset(reset),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .wb_add(wb_add), .wb_order(wb_order), .wb_data(wb_data),
    .ar_data(ar_data), .br_data(br_data),
    .rs_add(rs_add), .rd_add(rd_add),
    .op_valid(op_valid), .op_ready(op_ready)
  );

  // Reference model state
  logic [15:0] m_regs [8];
  bit          m_pend [8];
  bit          m_valid;
  logic [15:0] m_ar, m_br;
  logic [2:0]  m_rs, m_rd;

  function automatic bit reads_a(logic [15:0] i);
    return i[15:14] == 2'b11 || i[15:14] == 2'b01;
  endfunction

  function automatic bit reads_b(logic [15:0] i);
    return i[15:14] != 2'b10;
  endfunction

  function automatic bit writes_reg(logic [15:0] i);
    int o3;
    o3 = int'(i[7:4]);
    if (i[15:14] == 2'b11) return !(o3 == 7 || o3 >= 13);
    if (i[15:14] == 2'b10) return i[13:11] == 3'd0;
    return i[15:14] == 2'b00;
  endfunction

  function automatic logic [2:0] dest_of(logic [15:0] i);
    return (i[15:14] == 2'b00) ? i[13:11] : i[10:8];
  endfunction

  function automatic bit fwd(logic [2:0] r);
    return BYP && wb_order && wb_add == r;
  endfunction

  function automatic bit m_ready();
    bit ba, bb;
    ba = reads_a(instr) && m_pend[instr[13:11]] && !fwd(instr[13:11]);
    bb = reads_b(instr) && m_pend[instr[10:8]] && !fwd(instr[10:8]);
    return !reset && !ba && !bb && (!m_valid || op_ready);
  endfunction

  function automatic logic [15:0] m_val(bit used, logic [2:0] r);
    if (!used) return 16'h0;
    if (fwd(r)) return wb_data;
    return m_regs[r];
  endfunction

  // Advance DUT and model by one clock; no checking here.
  task automatic cycle();
    bit acc;
    logic [15:0] a, b;
    acc = instr_valid && m_ready();
    a = m_val(reads_a(instr), instr[13:11]);
    b = m_val(reads_b(instr), instr[10:8]);
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = 16'h0;
        m_pend[i] = 1'b0;
      end
      m_valid = 0; m_ar = 0; m_br = 0; m_rs = 0; m_rd = 0;
    end else begin
      if (acc) begin
        m_valid = 1'b1;
        m_ar = a; m_br = b;
        m_rs = instr[13:11]; m_rd = instr[10:8];
      end else if (op_ready) begin
        m_valid = 1'b0;
      end
      if (wb_order) begin
        m_regs[wb_add] = wb_data;
        m_pend[wb_add] = 1'b0;
      end
      if (acc && writes_reg(instr)) m_pend[dest_of(instr)] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; instr = 0; instr_valid = 1;
    wb_add = 0; wb_order = 0; wb_data = 0; op_ready = 1;
    #1;
    tests++;
    if (instr_ready !== 1'b0) begin
      fails++; $display("FAIL rst_ready: got %b want 0", instr_ready);
    end
    cycle();
    reset = 0; instr_valid = 0;
    tests++;
    if (op_valid !== 1'b0 || ar_data !== 16'h0 || br_data !== 16'h0
        || rs_add !== 3'd0 || rd_add !== 3'd0) begin
      fails++;
      $display("FAIL rst_state: got v=%b a=%h b=%h rs=%0d rd=%0d want zeros",
               op_valid, ar_data, br_data, rs_add, rd_add);
    end
    #1;
    tests++;
    if (instr_ready !== 1'b1) begin
      fails++; $display("FAIL rst_idle_ready: got %b want 1", instr_ready);
    end
  endtask

  task automatic test_read_after_reset();
    instr = {2'b11, 3'd1, 3'd2, 4'd0, 4'd0};
    instr_valid = 1;
    cycle();
    instr_valid = 0;
    tests++;
    if (op_valid !== 1'b1 || ar_data !== 16'h0 || br_data !== 16'h0
        || rs_add !== 3'd1 || rd_add !== 3'd2) begin
      fails++;
      $display("FAIL alu_read: got v=%b a=%h b=%h rs=%0d rd=%0d want 1 0 0 1 2",
               op_valid, ar_data, br_data, rs_add, rd_add);
    end
    instr = {2'b01, 3'd0, 3'd2, 8'h00};
    #1;
    tests++;
    if (instr_ready !== 1'b0) begin
      fails++; $display("FAIL pend2_stall: got %b want 0", instr_ready);
    end
    wb_order = 1; wb_add = 2; wb_data = 16'h0;
    cycle();
    wb_order = 0;
    #1;
    tests++;
    if (instr_ready !== 1'b1) begin
      fails++; $display("FAIL pend2_clear: got %b want 1", instr_ready);
    end
  endtask

  task automatic test_write_then_read();
    wb_order = 1; wb_add = 3; wb_data = 16'h1234;
    cycle();
    wb_order = 0;
    instr = {2'b01, 3'd3, 3'd4, 8'h00};
    instr_valid = 1;
    cycle();
    tests++;
    if (ar_data !== 16'h1234 || br_data !== 16'h0
        || rs_add !== 3'd3 || rd_add !== 3'd4) begin
      fails++;
      $display("FAIL st_read: got a=%h b=%h rs=%0d rd=%0d want 1234 0 3 4",
               ar_data, br_data, rs_add, rd_add);
    end
    #1;
    tests++;
    if (instr_ready !== 1'b1) begin
      fails++; $display("FAIL st_no_dest: got %b want 1", instr_ready);
    end
    instr_valid = 0;
    cycle();
  endtask

  task automatic test_hazard();
    instr = {2'b10, 3'd0, 3'd5, 8'h00};
    instr_valid = 1;
    cycle();
    instr = {2'b11, 3'd0, 3'd5, 4'd0, 4'd0};
    #1;
    tests++;
    if (instr_ready !== 1'b0) begin
      fails++; $display("FAIL haz_stall: got %b want 0", instr_ready);
    end
    wb_order = 1; wb_add = 5; wb_data = 16'h00AA;
    #1;
    tests++;
    if (instr_ready !== BYP) begin
      fails++; $display("FAIL haz_wb_cycle: got %b want %b", instr_ready, BYP);
    end
    cycle();
    wb_order = 0;
    if (!BYP) begin
      #1;
      tests++;
      if (instr_ready !== 1'b1) begin
        fails++; $display("FAIL haz_after_wb: got %b want 1", instr_ready);
      end
      cycle();
    end
    instr_valid = 0;
    tests++;
    if (op_valid !== 1'b1 || br_data !== 16'h00AA || rd_add !== 3'd5) begin
      fails++;
      $display("FAIL haz_data: got v=%b b=%h rd=%0d want 1 00aa 5",
               op_valid, br_data, rd_add);
    end
    wb_order = 1; wb_add = 5; wb_data = 16'h0;
    cycle();
    wb_order = 0;
  endtask

  task automatic test_backpressure();
    instr = {2'b11, 3'd3, 3'd4, 4'd7, 4'd0};
    instr_valid = 1; op_ready = 1;
    cycle();
    op_ready = 0;
    instr = {2'b01, 3'd1, 3'd3, 8'h00};
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (instr_ready !== 1'b0) begin
        fails++; $display("FAIL bp_ready[%0d]: got %b want 0", k, instr_ready);
      end
      cycle();
      tests++;
      if (op_valid !== 1'b1 || ar_data !== 16'h1234 || br_data !== 16'h0
          || rs_add !== 3'd3 || rd_add !== 3'd4) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b a=%h b=%h rs=%0d rd=%0d",
                 k, op_valid, ar_data, br_data, rs_add, rd_add);
      end
    end
    op_ready = 1;
    #1;
    tests++;
    if (instr_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: got %b want 1", instr_ready);
    end
    cycle();
    instr_valid = 0;
    tests++;
    if (op_valid !== 1'b1 || ar_data !== 16'h0 || br_data !== 16'h1234
        || rs_add !== 3'd1 || rd_add !== 3'd3) begin
      fails++;
      $display("FAIL bp_next: got v=%b a=%h b=%h rs=%0d rd=%0d",
               op_valid, ar_data, br_data, rs_add, rd_add);
    end
    cycle();
    tests++;
    if (op_valid !== 1'b0 || br_data !== 16'h1234) begin
      fails++;
      $display("FAIL drain: got v=%b b=%h want 0 1234", op_valid, br_data);
    end
  endtask

  task automatic test_collision();
    instr = {2'b11, 3'd1, 3'd2, 4'd0, 4'd0};
    instr_valid = 1;
    wb_order = 1; wb_add = 2; wb_data = 16'h5555;
    #1;
    tests++;
    if (instr_ready !== 1'b1) begin
      fails++; $display("FAIL coll_ready: got %b want 1", instr_ready);
    end
    cycle();
    wb_order = 0;
    tests++;
    if (br_data !== (BYP ? 16'h5555 : 16'h0)) begin
      fails++; $display("FAIL coll_data: got %h want %h",
                        br_data, BYP ? 16'h5555 : 16'h0);
    end
    instr = {2'b01, 3'd2, 3'd0, 8'h00};
    #1;
    tests++;
    if (instr_ready !== 1'b0) begin
      fails++; $display("FAIL coll_pending: got %b want 0", instr_ready);
    end
    instr_valid = 0;
    wb_order = 1; wb_add = 2; wb_data = 16'h0;
    cycle();
    wb_order = 0;
  endtask

  task automatic test_mid_reset();
    instr_valid = 1; op_ready = 1;
    for (int r = 0; r < 8; r++) begin
      instr = {2'b10, 3'd0, 3'(r), 8'h00};
      cycle();
    end
    instr = {2'b01, 3'd6, 3'd7, 8'h00};
    #1;
    tests++;
    if (instr_ready !== 1'b0 || op_valid !== 1'b1) begin
      fails++; $display("FAIL all_pending: got rdy=%b v=%b want 0 1",
                        instr_ready, op_valid);
    end
    instr_valid = 0;
    reset = 1;
    cycle();
    reset = 0;
    tests++;
    if (op_valid !== 1'b0 || ar_data !== 16'h0 || br_data !== 16'h0) begin
      fails++; $display("FAIL mid_reset: got v=%b a=%h b=%h want zeros",
                        op_valid, ar_data, br_data);
    end
    instr_valid = 1;
    for (int p = 0; p < 4; p++) begin
      instr = {2'b01, 3'(2 * p), 3'(2 * p + 1), 8'h00};
      #1;
      tests++;
      if (instr_ready !== 1'b1) begin
        fails++; $display("FAIL rst_unblock[%0d]: got %b want 1", p, instr_ready);
      end
      cycle();
      tests++;
      if (ar_data !== 16'h0 || br_data !== 16'h0) begin
        fails++; $display("FAIL rst_regs[%0d]: got a=%h b=%h want 0 0",
                          p, ar_data, br_data);
      end
    end
    instr_valid = 0;
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      instr       = 16'($urandom);
      instr_valid = ($urandom_range(3, 0) != 0);
      op_ready    = ($urandom_range(3, 0) != 0);
      wb_order    = ($urandom_range(1, 0) != 0);
      wb_add      = 3'($urandom_range(7, 0));
      wb_data     = 16'($urandom);
      #1;
      tests++;
      if (instr_ready !== m_ready()) begin
        fails++; $display("FAIL rnd_ready[%0d]: got %b want %b",
                          n, instr_ready, m_ready());
      end
      cycle();
      tests++;
      if (op_valid !== m_valid || ar_data !== m_ar || br_data !== m_br
          || rs_add !== m_rs || rd_add !== m_rd) begin
        fails++;
        $display("FAIL rnd_out[%0d]: got %b %h %h %0d %0d want %b %h %h %0d %0d",
                 n, op_valid, ar_data, br_data, rs_add, rd_add,
                 m_valid, m_ar, m_br, m_rs, m_rd);
      end
    end
    wb_order = 0;
    instr_valid = 0;
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_then_read();
    test_hazard();
    test_backpressure();
    test_collision();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
